qa_shim_c0_rd_arb2: RTL

//  - Shares one CCI channel 0 read-request path between two AFU clients.
//  - Each client presents a buffered request port (valid/hdr, explicit deq), i.e. the afu_buf side of a buffering shim.
//  - Round-robin grants, tags each issued request with the client id and routes read responses back by tag.
//  - Per-client outstanding limit keeps one client from starving the other.

---
 rtl/qa_shim_c0_rd_arb2.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/qa_shim_c0_rd_arb2.sv
// qa_shim_c0_rd_arb2
//   Shares one CCI channel 0 read-request path between two buffered AFU
//   clients. Round-robin grant, client id stamped into the tag MSB of the
//   issued header, responses routed back by that tag bit. A per-client
//   in-flight limit keeps either client from monopolising the channel.
//   Optional feature macro: QA_SHIM_C0_ARB_STATS_EN adds grant and
//   blocked-cycle counters (stat_grants_c0, stat_grants_c1, stat_blocked).
module qa_shim_c0_rd_arb2 #(
  parameter int CCI_TX_HDR_WIDTH = 61,
  parameter int CCI_RX_HDR_WIDTH = 18,
  parameter int CCI_DATA_WIDTH   = 512,
  parameter int CCI_TAG_WIDTH    = 13,
  parameter int MAX_OUTSTANDING  = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  // Client request side (head of each client's buffering FIFO)
  input  logic [1:0]                          c_req_valid,
  input  logic [1:0][CCI_TX_HDR_WIDTH-1:0]    c_req_hdr,
  output logic [1:0]                          c_req_deq,
  // CCI channel 0 transmit
  output logic                                tx_rd_valid,
  output logic [CCI_TX_HDR_WIDTH-1:0]         tx_hdr,
  input  logic                                tx_alm_full,
  // CCI channel 0 read responses
  input  logic                                rx_rd_valid,
  input  logic [CCI_RX_HDR_WIDTH-1:0]         rx_hdr,
  input  logic [CCI_DATA_WIDTH-1:0]           rx_data,
  // Responses fanned out to the clients
  output logic [1:0]                          c_rx_rd_valid,
  output logic [CCI_RX_HDR_WIDTH-1:0]         c_rx_hdr,
  output logic [CCI_DATA_WIDTH-1:0]           c_rx_data,
  output logic                                err_underflow
`ifdef QA_SHIM_C0_ARB_STATS_EN
  ,
  output logic [31:0]                         stat_grants_c0,
  output logic [31:0]                         stat_grants_c1,
  output logic [31:0]                         stat_blocked
`endif
);

  localparam int TAG_MSB = CCI_TAG_WIDTH - 1;
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Round-robin priority pointer: which client wins a tie.
  typedef enum logic {
    PRIO_C0 = 1'b0,
    PRIO_C1 = 1'b1
  } prio_t;

  prio_t                    prio;
  prio_t                    prio_nxt;

  logic [1:0]               eligible;
  logic [1:0]               grant;
  logic                     grant_any;
  logic                     grant_sel;     // index of the granted client
  logic [CCI_TX_HDR_WIDTH-1:0] grant_hdr;

  logic [1:0][CNT_W-1:0]    outstanding;
  logic [1:0][CNT_W-1:0]    outstanding_nxt;
  logic [1:0]               rsp_hit;
  logic [1:0]               underflow_hit;

  // ------------------------------------------------------------------
  // Request side
  // ------------------------------------------------------------------

  // A client may be granted when it has a head entry, is under its
  // in-flight limit, and CCI is not almost full. Reset blocks any grant.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      eligible[c] = c_req_valid[c] && (outstanding[c] < CNT_MAX) &&
                    !tx_alm_full && !reset;
    end
  end

  // Pick at most one winner: a tie goes to the pointer, otherwise the
  // only eligible client wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    grant = 2'b00;
    if (eligible == 2'b11) begin
      grant = (prio == PRIO_C1) ? 2'b10 : 2'b01;
    end else begin
      grant = eligible;
    end
  end

  assign grant_any = |grant;
  assign grant_sel = grant[1];
  assign c_req_deq = grant;

  // Stamp the winner's id into the tag MSB of its header.
  always_comb begin
    grant_hdr          = c_req_hdr[grant_sel];
    grant_hdr[TAG_MSB] = grant_sel;
  end

  // Pointer next state: move past the winner after a grant, else hold.
  always_comb begin
    prio_nxt = prio;
    if (grant_any) begin
      prio_nxt = grant_sel ? PRIO_C0 : PRIO_C1;
    end
  end

  // Pointer state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (reset) begin
      prio <= PRIO_C0;
    end else begin
      prio <= prio_nxt;
    end
  end

  // Output register: a grant issues to CCI on the following cycle. Once
  // loaded it always issues; CCI reserves slots beyond almost-full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_rd_valid <= 1'b0;
      tx_hdr      <= '0;
    end else begin
      tx_rd_valid <= grant_any;
      if (grant_any) begin
        tx_hdr <= grant_hdr;
      end
    end
  end

  // ------------------------------------------------------------------
  // Response side
  // ------------------------------------------------------------------

  // Route by tag MSB with zero latency; the MSB is hidden from clients.
  always_comb begin
    rsp_hit[0]        = rx_rd_valid && (rx_hdr[TAG_MSB] == 1'b0);
    rsp_hit[1]        = rx_rd_valid && (rx_hdr[TAG_MSB] == 1'b1);
    c_rx_hdr          = rx_hdr;
    c_rx_hdr[TAG_MSB] = 1'b0;
  end

  assign c_rx_rd_valid = rsp_hit;
  assign c_rx_data     = rx_data;

  // ------------------------------------------------------------------
  // In-flight accounting
  // ------------------------------------------------------------------

  // Count up on grant, down on a routed response, unchanged when both
  // happen together. A response seen at zero saturates and is flagged.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      outstanding_nxt[c] = outstanding[c];
      underflow_hit[c]   = rsp_hit[c] && (outstanding[c] == '0);
      unique case ({grant[c], rsp_hit[c]})
        2'b10: outstanding_nxt[c] = outstanding[c] + CNT_ONE;
        2'b01: begin
          if (outstanding[c] != '0) begin
            outstanding_nxt[c] = outstanding[c] - CNT_ONE;
          end
        end
        default: outstanding_nxt[c] = outstanding[c];
      endcase
    end
  end

  // Per-client in-flight counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding_nxt;
    end
  end

  // Sticky debug flag for responses that had nothing to retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_underflow <= 1'b0;
    end else if (|underflow_hit) begin
      err_underflow <= 1'b1;
    end
  end

`ifdef QA_SHIM_C0_ARB_STATS_EN
  // ------------------------------------------------------------------
  // Statistics
  // ------------------------------------------------------------------

  logic blocked;

  // A cycle is blocked when someone has a request yet nobody is granted;
  // only almost-full or the in-flight limit can cause that.
  assign blocked = (|c_req_valid) && !grant_any;

  // Free-running 32-bit counters; natural wrap at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grants_c0 <= '0;
      stat_grants_c1 <= '0;
      stat_blocked   <= '0;
    end else begin
      if (grant[0]) stat_grants_c0 <= stat_grants_c0 + 32'd1;
      if (grant[1]) stat_grants_c1 <= stat_grants_c1 + 32'd1;
      if (blocked)  stat_blocked   <= stat_blocked + 32'd1;
    end
  end
`endif

endmodule
